// File: rtl/scoreboard_reg_file.sv
// Register file with per-register scoreboard busy bits; two combinational read ports, writes on posedge.
// Optional same-cycle write-to-read forwarding; Busy_Cnt/Any_Busy are registered copies of the post-edge busy state.
module scoreboard_reg_file #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   Adr1,
  input  logic [AW-1:0]   Adr2,
  output logic [XLEN-1:0] Read1,
  output logic [XLEN-1:0] Read2,
  output logic            Busy1,
  output logic            Busy2,
  input  logic            WeA,
  input  logic [AW-1:0]   AdrA,
  input  logic [XLEN-1:0] WdA,
  input  logic            WeB,
  input  logic [AW-1:0]   AdrB,
  input  logic [XLEN-1:0] WdB,
  input  logic            Claim_En,
  input  logic [AW-1:0]   Claim_Adr,
  output logic            Any_Busy,
  output logic [AW:0]     Busy_Cnt
);

  localparam int NREG = 2**AW;
  localparam bit BYP  = (BYPASS != 0);

  logic [NREG-1:0][XLEN-1:0] mem;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busy_nxt;
  logic [AW:0]               cnt_nxt;

  // A long-latency return clears its busy bit, but a same-cycle claim re-arms it.
  always_comb begin
    busy_nxt = busy;
    if (WeB) busy_nxt[AdrB] = 1'b0;
    if (Claim_En) busy_nxt[Claim_Adr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // Port A is written after port B so it wins on an address collision; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem      <= '0;
      busy     <= '0;
      Busy_Cnt <= '0;
      Any_Busy <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      Busy_Cnt <= cnt_nxt;
      Any_Busy <= |busy_nxt;
      if (WeB && (AdrB != '0)) mem[AdrB] <= WdB;
      if (WeA && (AdrA != '0)) mem[AdrA] <= WdA;
    end
  end

  always_comb begin
    Read1 = mem[Adr1];
    if (Adr1 == '0) Read1 = '0;
    else if (BYP && WeA && (AdrA == Adr1)) Read1 = WdA;
    else if (BYP && WeB && (AdrB == Adr1)) Read1 = WdB;
    Busy1 = (Adr1 != '0) && busy[Adr1];
  end

  always_comb begin
    Read2 = mem[Adr2];
    if (Adr2 == '0) Read2 = '0;
    else if (BYP && WeA && (AdrA == Adr2)) Read2 = WdA;
    else if (BYP && WeB && (AdrB == Adr2)) Read2 = WdB;
    Busy2 = (Adr2 != '0) && busy[Adr2];
  end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file: one forwarding instance and one non-forwarding instance on shared inputs.
module tb_scoreboard_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Adr1, Adr2, AdrA, AdrB, Claim_Adr;
  logic        WeA, WeB, Claim_En;
  logic [31:0] WdA, WdB;

  logic [31:0] r1_b, r2_b, r1_n, r2_n;
  logic        b1_b, b2_b, b1_n, b2_n;
  logic        any_b, any_n;
  logic [5:0]  cnt_b, cnt_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scoreboard_reg_file #(.XLEN(32), .AW(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .Adr1(Adr1), .Adr2(Adr2),
    .Read1(r1_b), .Read2(r2_b), .Busy1(b1_b), .Busy2(b2_b),
    .WeA(WeA), .AdrA(AdrA), .WdA(WdA), .WeB(WeB), .AdrB(AdrB), .WdB(WdB),
    .Claim_En(Claim_En), .Claim_Adr(Claim_Adr), .Any_Busy(any_b), .Busy_Cnt(cnt_b)
  );

  scoreboard_reg_file #(.XLEN(32), .AW(5), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .Adr1(Adr1), .Adr2(Adr2),
    .Read1(r1_n), .Read2(r2_n), .Busy1(b1_n), .Busy2(b2_n),
    .WeA(WeA), .AdrA(AdrA), .WdA(WdA), .WeB(WeB), .AdrB(AdrB), .WdB(WdB),
    .Claim_En(Claim_En), .Claim_Adr(Claim_Adr), .Any_Busy(any_n), .Busy_Cnt(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WeA = 1'b0; WeB = 1'b0; Claim_En = 1'b0;
    AdrA = '0; AdrB = '0; Claim_Adr = '0; WdA = '0; WdB = '0;
  endtask

  task automatic chk_cnt(input string tag, input logic [5:0] exp_cnt);
    chk({tag, "_cnt_byp"}, {26'd0, cnt_b}, {26'd0, exp_cnt});
    chk({tag, "_cnt_nob"}, {26'd0, cnt_n}, {26'd0, exp_cnt});
    chk({tag, "_any_byp"}, {31'd0, any_b}, {31'd0, exp_cnt != 6'd0});
    chk({tag, "_any_nob"}, {31'd0, any_n}, {31'd0, exp_cnt != 6'd0});
  endtask

  initial begin
    rst_n = 1'b0; Adr1 = '0; Adr2 = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;

    // Reset state across every address on both ports
    for (int a = 0; a < 32; a++) begin
      Adr1 = 5'(a); Adr2 = 5'(31 - a);
      #1;
      chk("rst_read1", r1_b, 32'h0);
      chk("rst_read2", r2_n, 32'h0);
      chk("rst_busy1", {31'd0, b1_b}, 32'd0);
      chk("rst_busy2", {31'd0, b2_n}, 32'd0);
    end
    chk_cnt("rst", 6'd0);

    // Port A write with same-cycle read of the same address
    WeA = 1'b1; AdrA = 5'd5; WdA = 32'hDEADBEEF; Adr1 = 5'd5;
    #1;
    chk("fwdA_byp", r1_b, 32'hDEADBEEF);
    chk("fwdA_nob_old", r1_n, 32'h0);
    tick(); idle();
    #1;
    chk("wrA_byp_next", r1_b, 32'hDEADBEEF);
    chk("wrA_nob_next", r1_n, 32'hDEADBEEF);

    // A and B to the same non-busy address: A forwarded and stored, no count change
    WeA = 1'b1; AdrA = 5'd6; WdA = 32'h77; WeB = 1'b1; AdrB = 5'd6; WdB = 32'h66; Adr2 = 5'd6;
    #1;
    chk("fwd_prec_byp", r2_b, 32'h77);
    chk("fwd_prec_nob", r2_n, 32'h0);
    tick(); idle();
    #1;
    chk("collide6_byp", r2_b, 32'h77);
    chk("collide6_nob", r2_n, 32'h77);
    chk_cnt("webNoUnderflow", 6'd0);

    // Port B alone forwards its data
    WeB = 1'b1; AdrB = 5'd8; WdB = 32'hCAFE; Adr2 = 5'd8;
    #1;
    chk("fwdB_byp", r2_b, 32'hCAFE);
    chk("fwdB_nob_old", r2_n, 32'h0);
    tick(); idle();

    // Claims on x7 then x9
    Claim_En = 1'b1; Claim_Adr = 5'd7;
    tick();
    chk_cnt("claim7", 6'd1);
    Claim_Adr = 5'd9;
    tick(); idle();
    chk_cnt("claim9", 6'd2);

    // Long-latency return to x7: busy shown pre-edge, cleared after
    WeB = 1'b1; AdrB = 5'd7; WdB = 32'h1234; Adr2 = 5'd7;
    #1;
    chk("ret7_busy_pre", {31'd0, b2_b}, 32'd1);
    chk("ret7_fwd_byp", r2_b, 32'h1234);
    tick(); idle();
    #1;
    chk("ret7_busy_post", {31'd0, b2_b}, 32'd0);
    chk("ret7_read_byp", r2_b, 32'h1234);
    chk("ret7_read_nob", r2_n, 32'h1234);
    chk_cnt("ret7", 6'd1);
    Adr1 = 5'd9;
    #1;
    chk("busy9", {31'd0, b1_n}, 32'd1);

    // Re-claim an already busy register
    Claim_En = 1'b1; Claim_Adr = 5'd9;
    tick(); idle();
    chk_cnt("reclaim9", 6'd1);

    // Claim and return on x3 in one cycle: claim wins
    Claim_En = 1'b1; Claim_Adr = 5'd3; WeB = 1'b1; AdrB = 5'd3; WdB = 32'h55;
    tick(); idle();
    Adr1 = 5'd3;
    #1;
    chk("claimwin3_data", r1_n, 32'h55);
    chk("claimwin3_busy", {31'd0, b1_b}, 32'd1);
    chk_cnt("claimwin3", 6'd2);

    // x4 busy, then A and B collide on it
    Claim_En = 1'b1; Claim_Adr = 5'd4;
    tick(); idle();
    chk_cnt("claim4", 6'd3);
    WeA = 1'b1; AdrA = 5'd4; WdA = 32'hA; WeB = 1'b1; AdrB = 5'd4; WdB = 32'hB;
    tick(); idle();
    Adr1 = 5'd4;
    #1;
    chk("collide4_data", r1_n, 32'hA);
    chk("collide4_busy", {31'd0, b1_n}, 32'd0);
    chk_cnt("collide4", 6'd2);

    // Everything aimed at x0 is ignored, including forwarding
    WeA = 1'b1; AdrA = 5'd0; WdA = 32'hFFFF_FFFF; WeB = 1'b1; AdrB = 5'd0; WdB = 32'h1111;
    Claim_En = 1'b1; Claim_Adr = 5'd0; Adr1 = 5'd0; Adr2 = 5'd0;
    #1;
    chk("x0_fwd_read1", r1_b, 32'h0);
    chk("x0_fwd_read2", r2_b, 32'h0);
    tick(); idle();
    #1;
    chk("x0_read", r1_n, 32'h0);
    chk("x0_busy", {31'd0, b1_b}, 32'd0);
    chk_cnt("x0", 6'd2);

    // Claims on x1..x3, then reset with a write and claim pending
    for (int r = 1; r <= 3; r++) begin
      Claim_En = 1'b1; Claim_Adr = 5'(r);
      tick();
    end
    idle();
    chk_cnt("claim123", 6'd4);
    rst_n = 1'b0; WeA = 1'b1; AdrA = 5'd1; WdA = 32'h99; Claim_En = 1'b1; Claim_Adr = 5'd5;
    tick();
    rst_n = 1'b1; idle();
    #1;
    chk_cnt("rst2", 6'd0);
    for (int a = 1; a < 10; a++) begin
      Adr1 = 5'(a); Adr2 = 5'(a);
      #1;
      chk("rst2_read_byp", r1_b, 32'h0);
      chk("rst2_read_nob", r2_n, 32'h0);
      chk("rst2_busy", {31'd0, b1_b | b2_n}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
